sensor_scanner: RTL

Upstream stage of the sensor change detector. Round-robins four analog sensors through an external 4:1 mux and an 8-bit serial ADC. Deserialises each conversion and presents it as a stable `r0`/`check` pair for the change-detect co-processor, which samples both every clock. Also emits per-sample and per-frame strobes for logging.

---
 rtl/sensor_scanner.sv | 115 +++++++++++
 1 files changed

// File: rtl/sensor_scanner.sv
// Round-robin scanner: steps an external 4:1 mux, runs an 8-bit serial ADC conversion per channel,
// and presents each sample as an atomic r0/check pair with valid/frame_done strobes.
module sensor_scanner #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       adc_sdo,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [1:0] mux_sel,
    output logic [7:0] r0,
    output logic [1:0] check,
    output logic       valid,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_r;
    logic [7:0] settle_cnt_r;
    logic [3:0] phase_r;
    logic [7:0] shift_r;

    // Scan FSM with all outputs registered; phase_r[0] is the half-bit (sclk low/high) phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            settle_cnt_r <= 8'd0;
            phase_r      <= 4'd0;
            shift_r      <= 8'd0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            mux_sel      <= 2'd0;
            r0           <= 8'd0;
            check        <= 2'd0;
            valid        <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    if (enable) begin
                        state_r      <= SETTLE;
                        settle_cnt_r <= 8'd0;
                        busy         <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r  <= CONVERT;
                        phase_r  <= 4'd0;
                        shift_r  <= 8'd0;
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                    end
                end
                CONVERT: begin
                    // Capture on the edge that ends each sclk-high clock.
                    if (phase_r[0]) begin
                        shift_r <= {shift_r[6:0], adc_sdo};
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (phase_r == 4'd15) begin
                        state_r    <= PRESENT;
                        adc_cs_n   <= 1'b1;
                        adc_sclk   <= 1'b0;
                        r0         <= {shift_r[6:0], adc_sdo};
                        check      <= mux_sel;
                        valid      <= 1'b1;
                        frame_done <= (mux_sel == 2'd3);
                    end else begin
                        phase_r  <= phase_r + 4'd1;
                        adc_sclk <= ~phase_r[0];
                    end
                end
                PRESENT: begin
                    mux_sel <= mux_sel + 2'd1;
                    if (enable) begin
                        state_r      <= SETTLE;
                        settle_cnt_r <= 8'd0;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
